// File: rtl/wave_sequencer_ctrl.sv
// Profile sequencer for one triangular up/down counter: loads limits/step/preset,
// generates the counter tick, and counts reversal carries per profile.
module wave_sequencer_ctrl #(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned N_PROF   = 4,
  localparam int unsigned PW      = $clog2(N_PROF)
) (
  input  logic          qzt_clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_addr,
  input  logic [31:0]   cfg_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          cnt_carry,
  output logic          cnt_clk,
  output logic          cnt_set,
  output logic [11:0]   cnt_preset,
  output logic [11:0]   cnt_limit_up,
  output logic [11:0]   cnt_limit_down,
  output logic [2:0]    cnt_step,
  output logic          busy,
  output logic [PW-1:0] prof_idx,
  output logic          done,
  output logic          err
);

  localparam int unsigned DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N_PROF - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, NEXT, DONE} state_t;

  state_t        state;
  logic [31:0]   tbl [N_PROF];
  logic [4:0]    sh_n_half;
  logic [4:0]    half_cnt;
  logic [DW-1:0] div;
  logic          carry_q;
  logic          ran;
  logic          load_ok;
  logic          load_err;

  logic [PW-1:0] ld_idx;
  logic [31:0]   ld_slot;
  logic [11:0]   ld_up;
  logic [11:0]   ld_down;
  logic [2:0]    ld_step;
  logic [4:0]    ld_nh;
  logic          ld_valid;
  logic          go_load;

  // Profile table, writable at any time
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_PROF; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Slot that the next LOAD will use, decoded one edge ahead so cnt_set is registered
  always_comb begin
    ld_idx = '0;
    if (state == NEXT && idx_not_last()) ld_idx = prof_idx + PW'(1);
    ld_slot  = tbl[ld_idx];
    ld_up    = ld_slot[11:0];
    ld_down  = ld_slot[23:12];
    ld_step  = ld_slot[26:24];
    ld_nh    = ld_slot[31:27];
    ld_valid = (ld_nh != 5'd0) && ({1'b0, ld_up} >= ({1'b0, ld_down} + 13'd3));
    go_load  = 1'b0;
    case (state)
      IDLE:    go_load = start && !stop;
      NEXT:    go_load = !stop && (idx_not_last() || (loop && ran));
      default: go_load = 1'b0;
    endcase
  end

  function automatic logic idx_not_last();
    return prof_idx != LAST_IDX;
  endfunction

  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt_clk        <= 1'b0;
      cnt_set        <= 1'b0;
      cnt_preset     <= '0;
      cnt_limit_up   <= '0;
      cnt_limit_down <= '0;
      cnt_step       <= '0;
      busy           <= 1'b0;
      prof_idx       <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
      sh_n_half      <= '0;
      half_cnt       <= '0;
      div            <= '0;
      carry_q        <= 1'b0;
      ran            <= 1'b0;
      load_ok        <= 1'b0;
      load_err       <= 1'b0;
    end else begin
      carry_q <= cnt_carry;
      cnt_set <= 1'b0;
      cnt_clk <= 1'b0;
      done    <= 1'b0;
      if (stop && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go_load) begin
            err   <= 1'b0;
            ran   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
          LOAD: if (load_ok) begin
            ran      <= 1'b1;
            half_cnt <= '0;
            div      <= '0;
            state    <= RUN;
          end else begin
            if (load_err) err <= 1'b1;
            state <= NEXT;
          end
          RUN: if (half_cnt == sh_n_half) begin
            state <= NEXT;
          end else begin
            if (cnt_carry && !carry_q) half_cnt <= half_cnt + 5'd1;
            if (div == DIV_LAST) begin
              div     <= '0;
              cnt_clk <= 1'b1;
            end else begin
              div <= div + DW'(1);
            end
          end
          NEXT: if (go_load) begin
            if (!idx_not_last()) ran <= 1'b0;
            state <= LOAD;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      // Entering LOAD: capture the slot into the shadows and drive the counter set
      if (go_load) begin
        prof_idx <= ld_idx;
        load_ok  <= ld_valid;
        load_err <= (ld_nh != 5'd0) && !ld_valid;
        if (ld_valid) begin
          cnt_set        <= 1'b1;
          cnt_preset     <= ld_down + 12'd1;
          cnt_limit_up   <= ld_up;
          cnt_limit_down <= ld_down;
          cnt_step       <= ld_step;
          sh_n_half      <= ld_nh;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_sequencer_ctrl.sv
// Directed bench for wave_sequencer_ctrl with TICK_DIV=4, N_PROF=4.
module tb_wave_sequencer_ctrl;

  logic        qzt_clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        start;
  logic        stop;
  logic        loop;
  logic        cnt_carry;
  logic        cnt_clk;
  logic        cnt_set;
  logic [11:0] cnt_preset;
  logic [11:0] cnt_limit_up;
  logic [11:0] cnt_limit_down;
  logic [2:0]  cnt_step;
  logic        busy;
  logic [1:0]  prof_idx;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errs   = 0;

  wave_sequencer_ctrl #(.TICK_DIV(4), .N_PROF(4)) dut (
    .qzt_clk(qzt_clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .stop(stop), .loop(loop),
    .cnt_carry(cnt_carry), .cnt_clk(cnt_clk), .cnt_set(cnt_set),
    .cnt_preset(cnt_preset), .cnt_limit_up(cnt_limit_up),
    .cnt_limit_down(cnt_limit_down), .cnt_step(cnt_step), .busy(busy),
    .prof_idx(prof_idx), .done(done), .err(err)
  );

  always #5 qzt_clk = ~qzt_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [11:0] up, input logic [11:0] dn,
                     input logic [2:0] st, input logic [4:0] nh);
    cfg_addr = a;
    cfg_data = {nh, st, dn, up};
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic carry_pulse();
    cnt_carry = 1'b1;
    tick();
    cnt_carry = 1'b0;
  endtask

  int  n;
  logic seen;

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_data = 0;
    start = 0; stop = 0; loop = 0; cnt_carry = 0;
    repeat (2) @(posedge qzt_clk);
    #1 reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_up", 32'(cnt_limit_up), 0);
    check("rst_done", 32'(done), 0);

    // Empty table: LOAD/NEXT per slot then done
    start = 1; tick(); start = 0;
    check("empty_busy", 32'(busy), 1);
    seen = cnt_set;
    n = 0;
    while (!done && n < 40) begin tick(); n++; seen |= cnt_set; end
    check("empty_len", 32'(n), 8);
    check("empty_set", 32'(seen), 0);
    check("empty_err", 32'(err), 0);
    tick();
    check("empty_idle", 32'(busy), 0);
    check("empty_pulse", 32'(done), 0);

    // Single profile, two half periods
    cfg(0, 12'd100, 12'd10, 3'd0, 5'd2);
    start = 1; tick(); start = 0;
    check("p0_set", 32'(cnt_set), 1);
    check("p0_preset", 32'(cnt_preset), 11);
    check("p0_up", 32'(cnt_limit_up), 100);
    check("p0_down", 32'(cnt_limit_down), 10);
    tick();
    check("p0_run_set", 32'(cnt_set), 0);
    repeat (3) tick();
    check("p0_tick_early", 32'(cnt_clk), 0);
    tick();
    check("p0_tick", 32'(cnt_clk), 1);
    tick();
    check("p0_tick_width", 32'(cnt_clk), 0);
    carry_pulse(); tick(); carry_pulse();
    check("p0_still_run", 32'(busy), 1);
    wait_done(40, n);
    check("p0_done_lat", 32'(n), 8);
    check("p0_clk_stop", 32'(cnt_clk), 0);
    tick();
    check("p0_idle", 32'(busy), 0);

    // Two profiles looping, then stop
    cfg(0, 12'd100, 12'd10, 3'd1, 5'd1);
    cfg(1, 12'd200, 12'd20, 3'd2, 5'd1);
    loop = 1;
    start = 1; tick(); start = 0;
    check("lp_idx0", 32'(prof_idx), 0);
    check("lp_step0", 32'(cnt_step), 1);
    tick(); carry_pulse(); tick();
    check("lp_gap_next_clk", 32'(cnt_clk), 0);
    check("lp_gap_next_set", 32'(cnt_set), 0);
    tick();
    check("lp_idx1", 32'(prof_idx), 1);
    check("lp_set1", 32'(cnt_set), 1);
    check("lp_up1", 32'(cnt_limit_up), 200);
    check("lp_preset1", 32'(cnt_preset), 21);
    tick(); carry_pulse(); tick();
    seen = 0;
    repeat (5) begin tick(); seen |= done; end
    check("lp_wrap_idx", 32'(prof_idx), 0);
    check("lp_wrap_set", 32'(cnt_set), 1);
    check("lp_wrap_up", 32'(cnt_limit_up), 100);
    check("lp_no_done", 32'(seen), 0);
    tick(); tick();
    stop = 1; tick(); stop = 0;
    check("stop_busy", 32'(busy), 0);
    check("stop_done", 32'(done), 0);
    check("stop_hold_up", 32'(cnt_limit_up), 100);
    tick();
    check("stop_done2", 32'(done), 0);
    loop = 0;

    // Invalid slot 1 (up < down+3)
    cfg(1, 12'd12, 12'd10, 3'd0, 5'd1);
    start = 1; tick(); start = 0;
    tick(); carry_pulse(); tick(); tick();
    check("inv_set", 32'(cnt_set), 0);
    check("inv_idx", 32'(prof_idx), 1);
    check("inv_hold_up", 32'(cnt_limit_up), 100);
    tick();
    check("inv_err", 32'(err), 1);
    wait_done(40, n);
    check("inv_done_lat", 32'(n), 5);
    tick();
    check("inv_err_sticky", 32'(err), 1);
    start = 1; tick(); start = 0;
    check("inv_err_clr", 32'(err), 0);
    stop = 1; tick(); stop = 0;

    // Write to active slot during RUN; boundary-valid slot 1; carry high across LOAD
    cfg(0, 12'd100, 12'd10, 3'd0, 5'd1);
    cfg(1, 12'd13, 12'd10, 3'd3, 5'd1);
    loop = 1;
    start = 1; tick(); start = 0;
    tick();
    cfg(0, 12'd300, 12'd30, 3'd5, 5'd1);
    check("we_hold_up", 32'(cnt_limit_up), 100);
    check("we_hold_step", 32'(cnt_step), 0);
    carry_pulse(); tick(); tick();
    check("bnd_set", 32'(cnt_set), 1);
    check("bnd_up", 32'(cnt_limit_up), 13);
    check("bnd_step", 32'(cnt_step), 3);
    tick(); carry_pulse(); tick();
    repeat (5) tick();
    check("we_new_set", 32'(cnt_set), 1);
    check("we_new_up", 32'(cnt_limit_up), 300);
    check("we_new_preset", 32'(cnt_preset), 31);
    check("we_new_step", 32'(cnt_step), 5);
    cnt_carry = 1;
    tick();
    repeat (4) tick();
    check("carry_ld_run", 32'(cnt_clk), 1);
    cnt_carry = 0; tick();
    carry_pulse(); tick(); tick();
    check("carry_ld_next", 32'(prof_idx), 1);
    stop = 1; tick(); stop = 0;
    loop = 0;

    // start and stop together in IDLE
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("ss_busy", 32'(busy), 0);
    check("ss_set", 32'(cnt_set), 0);
    tick();
    check("ss_busy2", 32'(busy), 0);

    // Asynchronous reset mid-RUN
    start = 1; tick(); start = 0;
    tick();
    check("ar_pre_busy", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_up", 32'(cnt_limit_up), 0);
    check("ar_preset", 32'(cnt_preset), 0);
    check("ar_step", 32'(cnt_step), 0);
    #1 reset = 1'b0;
    start = 1; tick(); start = 0;
    wait_done(40, n);
    check("ar_empty_lat", 32'(n), 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
